// File: rtl/axi_mm_axis_reader.sv
// Reads a byte range from AXI4 memory in page-safe INCR bursts and replays the
// returned beats on an AXI4-Stream port, trimming tkeep on the final beat.
module axi_mm_axis_reader #(
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int ADDR_WIDTH = 34,
   parameter int ID_WIDTH   = 8,
   parameter int LEN_WIDTH  = 20,
   parameter int MAX_BURST  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] s_cmd_addr,
   input  logic [LEN_WIDTH-1:0]  s_cmd_len,
   input  logic                  s_cmd_valid,
   output logic                  s_cmd_ready,
   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arlock,
   output logic [3:0]            m_axi_arcache,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [ID_WIDTH-1:0]   m_axi_rid,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  busy,
   output logic                  error
);

   localparam int BYTES      = KEEP_WIDTH;
   localparam int OFFS       = $clog2(BYTES);
   localparam int PAGE_BEATS = 4096 / BYTES;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic [8:0]            size_q, size_d;
   logic [8:0]            beat_cnt_q, beat_cnt_d;
   logic                  arvalid_q, arvalid_d;
   logic [KEEP_WIDTH-1:0] last_keep_q, last_keep_d;
   logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
   logic                  tlast_q, tlast_d;
   logic                  tvalid_q, tvalid_d;
   logic                  busy_q, busy_d;
   logic                  error_q, error_d;
   logic                  zlen_q, zlen_d;

   logic                  cmd_fire;
   logic                  r_fire;
   logic                  out_fire;
   logic                  last_of_burst;
   logic                  is_final;
   logic [15:0]           rem_capped;
   logic [15:0]           page_left;
   logic [15:0]           burst_beats;
   logic [OFFS-1:0]       len_mod;
   logic                  unused_inputs;

   assign unused_inputs = ^{m_axi_rid, m_axi_rlast};

   assign m_axi_arid    = '0;
   assign m_axi_arsize  = 3'(OFFS);
   assign m_axi_arburst = 2'b01;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = 4'b0000;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arlen   = 8'(size_q - 9'd1);
   assign m_axi_arvalid = arvalid_q;

   assign s_cmd_ready   = (state_q == S_IDLE) && !busy_q;
   assign m_axi_rready  = (state_q == S_DATA) && (!tvalid_q || m_axis_tready);

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tkeep  = tkeep_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tvalid = tvalid_q;
   assign busy          = busy_q;
   assign error         = error_q;

   assign cmd_fire = s_cmd_valid && s_cmd_ready;
   assign r_fire   = m_axi_rvalid && m_axi_rready;
   assign out_fire = tvalid_q && m_axis_tready;
   assign len_mod  = s_cmd_len[OFFS-1:0];

   // Burst length is the smallest of beats left, MAX_BURST and beats to the 4 KiB page end.
   always_comb begin
      rem_capped  = (rem_q > LEN_WIDTH'(MAX_BURST)) ? 16'(MAX_BURST) : 16'(rem_q);
      page_left   = 16'(PAGE_BEATS) - 16'(addr_q[11:OFFS]);
      burst_beats = (page_left < rem_capped) ? page_left : rem_capped;
   end

   assign last_of_burst = (beat_cnt_q + 9'd1) == size_q;
   assign is_final      = last_of_burst && (rem_q == '0);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      size_d      = size_q;
      beat_cnt_d  = beat_cnt_q;
      arvalid_d   = arvalid_q;
      last_keep_d = last_keep_q;
      busy_d      = busy_q;
      error_d     = error_q;
      zlen_d      = 1'b0;

      if (zlen_q || (out_fire && tlast_q)) begin
         busy_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (cmd_fire) begin
               addr_d      = s_cmd_addr & ~ADDR_WIDTH'(BYTES - 1);
               rem_d       = (s_cmd_len >> OFFS) + LEN_WIDTH'(|len_mod);
               last_keep_d = (len_mod == '0) ? '1 : ~({KEEP_WIDTH{1'b1}} << len_mod);
               error_d     = 1'b0;
               busy_d      = 1'b1;
               if (s_cmd_len == '0) begin
                  zlen_d = 1'b1;
               end else begin
                  state_d = S_ADDR;
               end
            end
         end
         S_ADDR: begin
            if (!arvalid_q) begin
               arvalid_d = 1'b1;
               size_d    = 9'(burst_beats);
            end else if (m_axi_arready) begin
               arvalid_d  = 1'b0;
               addr_d     = addr_q + (ADDR_WIDTH'(size_q) << OFFS);
               rem_d      = rem_q - LEN_WIDTH'(size_q);
               beat_cnt_d = '0;
               state_d    = S_DATA;
            end
         end
         S_DATA: begin
            // The local beat count ends the burst; rlast is deliberately not trusted.
            if (r_fire) begin
               if (last_of_burst) begin
                  beat_cnt_d = '0;
                  state_d    = (rem_q == '0) ? S_IDLE : S_ADDR;
               end else begin
                  beat_cnt_d = beat_cnt_q + 9'd1;
               end
               if (m_axi_rresp != 2'b00) begin
                  error_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // One-entry output register; rready only opens when this slot is free or draining.
   always_comb begin
      tdata_d  = tdata_q;
      tkeep_d  = tkeep_q;
      tlast_d  = tlast_q;
      tvalid_d = tvalid_q;
      if (r_fire) begin
         tdata_d  = m_axi_rdata;
         tvalid_d = 1'b1;
         tlast_d  = is_final;
         tkeep_d  = is_final ? last_keep_q : '1;
      end else if (out_fire) begin
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         size_q      <= 9'd1;
         beat_cnt_q  <= '0;
         arvalid_q   <= 1'b0;
         last_keep_q <= '1;
         tdata_q     <= '0;
         tkeep_q     <= '0;
         tlast_q     <= 1'b0;
         tvalid_q    <= 1'b0;
         busy_q      <= 1'b0;
         error_q     <= 1'b0;
         zlen_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         size_q      <= size_d;
         beat_cnt_q  <= beat_cnt_d;
         arvalid_q   <= arvalid_d;
         last_keep_q <= last_keep_d;
         tdata_q     <= tdata_d;
         tkeep_q     <= tkeep_d;
         tlast_q     <= tlast_d;
         tvalid_q    <= tvalid_d;
         busy_q      <= busy_d;
         error_q     <= error_d;
         zlen_q      <= zlen_d;
      end
   end

endmodule

// File: tb/tb_axi_mm_axis_reader.sv
// Bench for axi_mm_axis_reader: a randomised AXI read slave backed by an address-derived
// memory image, and a reference that splits commands into bursts and beats arithmetically.
module tb_axi_mm_axis_reader;

   localparam int DW = 512;
   localparam int KW = DW / 8;
   localparam int AW = 34;
   localparam int IW = 8;
   localparam int LW = 20;
   localparam int MB = 16;

   logic          clk;
   logic          rst;
   logic [AW-1:0] s_cmd_addr;
   logic [LW-1:0] s_cmd_len;
   logic          s_cmd_valid;
   logic          s_cmd_ready;
   logic [IW-1:0] arid;
   logic [AW-1:0] araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic          arlock;
   logic [3:0]    arcache;
   logic [2:0]    arprot;
   logic          arvalid;
   logic          arready;
   logic [IW-1:0] rid;
   logic [DW-1:0] rdata;
   logic [1:0]    rresp;
   logic          rlast;
   logic          rvalid;
   logic          rready;
   logic [DW-1:0] tdata;
   logic [KW-1:0] tkeep;
   logic          tlast;
   logic          tvalid;
   logic          tready;
   logic          busy;
   logic          error;

   int total = 0;
   int bad   = 0;

   logic [AW-1:0] ar_addr_log[$];
   logic [7:0]    ar_len_log[$];
   logic [2:0]    ar_size_log[$];
   logic [1:0]    ar_burst_log[$];
   logic [DW-1:0] s_data_log[$];
   logic [KW-1:0] s_keep_log[$];
   logic          s_last_log[$];

   logic [AW-1:0] exp_ar_addr[$];
   logic [7:0]    exp_ar_len[$];
   logic [DW-1:0] exp_data[$];
   logic [KW-1:0] exp_keep[$];
   logic          exp_last[$];

   logic [AW-1:0] pend_addr[$];
   int            pend_left[$];
   int            r_beat_cnt = 0;
   int            err_beat   = -1;
   bit            rnd_tready = 1'b0;

   axi_mm_axis_reader #(
      .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ADDR_WIDTH(AW),
      .ID_WIDTH(IW), .LEN_WIDTH(LW), .MAX_BURST(MB)
   ) dut (
      .clk(clk), .rst(rst),
      .s_cmd_addr(s_cmd_addr), .s_cmd_len(s_cmd_len),
      .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
      .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
      .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arlock(arlock),
      .m_axi_arcache(arcache), .m_axi_arprot(arprot),
      .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
      .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
      .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
      .m_axis_tvalid(tvalid), .m_axis_tready(tready),
      .busy(busy), .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory image: every 64-byte line holds a distinct pattern derived from its address.
   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      logic [DW-1:0] w;
      for (int k = 0; k < DW / 32; k++) begin
         w[32*k +: 32] = (a[31:0] * 32'h9E3779B1) ^ (32'(k) << 24) ^ 32'h5A5A0000;
      end
      return w;
   endfunction

   // Reference: page- and MAX_BURST-limited burst split plus the expected stream beats.
   task automatic build_expected(input logic [AW-1:0] addr, input int len);
      logic [AW-1:0] a;
      logic [AW-1:0] base;
      int nb, left, page, sz;
      exp_ar_addr.delete(); exp_ar_len.delete();
      exp_data.delete(); exp_keep.delete(); exp_last.delete();
      base = {addr[AW-1:6], 6'b0};
      a    = base;
      nb   = (len + KW - 1) / KW;
      left = nb;
      while (left > 0) begin
         page = (4096 - int'(a[11:0])) / KW;
         sz   = left;
         if (sz > MB) sz = MB;
         if (sz > page) sz = page;
         exp_ar_addr.push_back(a);
         exp_ar_len.push_back(8'(sz - 1));
         a    = a + AW'(sz * KW);
         left = left - sz;
      end
      for (int i = 0; i < nb; i++) begin
         exp_data.push_back(mem_word(base + AW'(i * KW)));
         if (i == nb - 1 && (len % KW) != 0) exp_keep.push_back((64'd1 << (len % KW)) - 64'd1);
         else exp_keep.push_back({KW{1'b1}});
         exp_last.push_back(i == nb - 1);
      end
   endtask

   task automatic clear_logs();
      ar_addr_log.delete(); ar_len_log.delete(); ar_size_log.delete(); ar_burst_log.delete();
      s_data_log.delete(); s_keep_log.delete(); s_last_log.delete();
   endtask

   task automatic do_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l, output bit to);
      int n;
      @(posedge clk); #1;
      s_cmd_addr = a; s_cmd_len = l; s_cmd_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_cmd_ready && n < 2000) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      s_cmd_valid = 1'b0;
      to = (n >= 2000);
      n = 0;
      @(negedge clk);
      while (busy && n < 20000) begin @(negedge clk); n++; end
      if (n >= 20000) to = 1'b1;
   endtask

   // AXI read slave and stream sink; handshakes are observed at the negedge before they complete.
   initial begin
      bit r_hs, rst_seen;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = '0; tready = 1'b1;
      forever begin
         @(negedge clk);
         rst_seen = rst;
         r_hs     = rvalid && rready;
         if (!rst_seen) begin
            if (r_hs && pend_addr.size() > 0) begin
               r_beat_cnt++;
               pend_left[0] = pend_left[0] - 1;
               pend_addr[0] = pend_addr[0] + AW'(KW);
               if (pend_left[0] == 0) begin
                  void'(pend_addr.pop_front());
                  void'(pend_left.pop_front());
               end
            end
            if (arvalid && arready) begin
               ar_addr_log.push_back(araddr); ar_len_log.push_back(arlen);
               ar_size_log.push_back(arsize); ar_burst_log.push_back(arburst);
               pend_addr.push_back(araddr); pend_left.push_back(int'(arlen) + 1);
            end
            if (tvalid && tready) begin
               s_data_log.push_back(tdata); s_keep_log.push_back(tkeep); s_last_log.push_back(tlast);
            end
         end
         @(posedge clk); #1;
         if (rst_seen) begin
            pend_addr.delete(); pend_left.delete();
            rvalid = 1'b0; arready = 1'b0; tready = 1'b1;
         end else begin
            arready = ($urandom_range(3) != 0);
            tready  = rnd_tready ? 1'($urandom_range(1)) : 1'b1;
            if (!(rvalid && !r_hs)) begin
               if (pend_addr.size() > 0 && $urandom_range(3) != 0) begin
                  rvalid = 1'b1;
                  rdata  = mem_word(pend_addr[0]);
                  rresp  = (r_beat_cnt == err_beat) ? 2'b10 : 2'b00;
                  rlast  = (pend_left[0] == 1);
               end else begin
                  rvalid = 1'b0;
               end
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({arvalid, rready, tvalid, tlast, busy, error, s_cmd_ready} !== 7'b0000001) begin
         bad++;
         $display("[TB] FAIL reset_outputs got=%b want=%b",
                  {arvalid, rready, tvalid, tlast, busy, error, s_cmd_ready}, 7'b0000001);
      end
      total++;
      if ({arid, arsize, arburst, arlock, arcache, arprot} !== {8'h00, 3'd6, 2'b01, 1'b0, 4'h0, 3'h0}) begin
         bad++;
         $display("[TB] FAIL ar_constants got=%h want=%h", {arid, arsize, arburst, arlock, arcache, arprot},
                  {8'h00, 3'd6, 2'b01, 1'b0, 4'h0, 3'h0});
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [AW-1:0] t_addr[4] = '{34'h1000, 34'h2000, 34'h0FC0, 34'h0};
      int            t_len[4]  = '{128, 100, 256, 2048};
      bit            t_rnd[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
      bit to;
      for (int i = 0; i < 4; i++) begin
         clear_logs();
         rnd_tready = t_rnd[i];
         build_expected(t_addr[i], t_len[i]);
         do_cmd(t_addr[i], LW'(t_len[i]), to);
         total++;
         if (to) begin bad++; $display("[TB] FAIL directed%0d_timeout got=1 want=0", i); end
         total++;
         if (ar_addr_log.size() != exp_ar_addr.size()) begin
            bad++;
            $display("[TB] FAIL directed%0d_ar_count got=%0d want=%0d", i, ar_addr_log.size(), exp_ar_addr.size());
         end else begin
            for (int j = 0; j < exp_ar_addr.size(); j++) begin
               total++;
               if ({ar_addr_log[j], ar_len_log[j], ar_size_log[j], ar_burst_log[j]} !==
                   {exp_ar_addr[j], exp_ar_len[j], 3'd6, 2'b01}) begin
                  bad++;
                  $display("[TB] FAIL directed%0d_ar%0d got addr=%h len=%0d size=%0d burst=%0d want addr=%h len=%0d size=6 burst=1",
                           i, j, ar_addr_log[j], ar_len_log[j], ar_size_log[j], ar_burst_log[j], exp_ar_addr[j], exp_ar_len[j]);
               end
            end
         end
         total++;
         if (s_data_log.size() != exp_data.size()) begin
            bad++;
            $display("[TB] FAIL directed%0d_beat_count got=%0d want=%0d", i, s_data_log.size(), exp_data.size());
         end else begin
            for (int j = 0; j < exp_data.size(); j++) begin
               total++;
               if ({s_data_log[j], s_keep_log[j], s_last_log[j]} !== {exp_data[j], exp_keep[j], exp_last[j]}) begin
                  bad++;
                  $display("[TB] FAIL directed%0d_beat%0d got data=%h keep=%h last=%b want data=%h keep=%h last=%b",
                           i, j, s_data_log[j][63:0], s_keep_log[j], s_last_log[j], exp_data[j][63:0], exp_keep[j], exp_last[j]);
               end
            end
         end
         if (i == 1 && s_keep_log.size() == 2) begin
            total++;
            if ({s_keep_log[1], s_last_log[1]} !== {64'h0000000FFFFFFFFF, 1'b1}) begin
               bad++;
               $display("[TB] FAIL partial_keep got=%h/%b want=0000000fffffffff/1", s_keep_log[1], s_last_log[1]);
            end
         end
      end
      rnd_tready = 1'b0;
   endtask

   task automatic test_zero_len();
      bit to;
      clear_logs();
      do_cmd(34'h3000, '0, to);
      repeat (20) @(negedge clk);
      total++;
      if (to || ar_addr_log.size() != 0 || s_data_log.size() != 0) begin
         bad++;
         $display("[TB] FAIL zero_len got timeout=%0d ars=%0d beats=%0d want 0/0/0", to, ar_addr_log.size(), s_data_log.size());
      end
      total++;
      if ({busy, s_cmd_ready} !== 2'b01) begin
         bad++;
         $display("[TB] FAIL zero_len_idle got busy/ready=%b want=01", {busy, s_cmd_ready});
      end
   endtask

   task automatic test_error();
      bit to;
      clear_logs();
      r_beat_cnt = 0;
      err_beat   = 0;
      build_expected(34'h5000, 128);
      do_cmd(34'h5000, 20'd128, to);
      total++;
      if (to || s_data_log.size() != 2) begin
         bad++;
         $display("[TB] FAIL error_beats got timeout=%0d beats=%0d want 0/2", to, s_data_log.size());
      end else begin
         for (int j = 0; j < 2; j++) begin
            total++;
            if ({s_data_log[j], s_keep_log[j], s_last_log[j]} !== {exp_data[j], exp_keep[j], exp_last[j]}) begin
               bad++;
               $display("[TB] FAIL error_beat%0d got data=%h last=%b want data=%h last=%b",
                        j, s_data_log[j][63:0], s_last_log[j], exp_data[j][63:0], exp_last[j]);
            end
         end
      end
      total++;
      if (error !== 1'b1) begin bad++; $display("[TB] FAIL error_sticky got=%b want=1", error); end
      err_beat = -1;
      clear_logs();
      do_cmd(34'h6000, 20'd64, to);
      total++;
      if (to || error !== 1'b0) begin
         bad++;
         $display("[TB] FAIL error_clear got error=%b timeout=%0d want 0/0", error, to);
      end
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] a;
      int            l;
      bit            to;
      rnd_tready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a = AW'($urandom_range(32'h3FFFF));
         l = int'($urandom_range(1500, 1));
         clear_logs();
         build_expected(a, l);
         do_cmd(a, LW'(l), to);
         total++;
         if (to || ar_addr_log.size() != exp_ar_addr.size() || s_data_log.size() != exp_data.size()) begin
            bad++;
            $display("[TB] FAIL b2b%0d_counts addr=%h len=%0d got to=%0d ars=%0d beats=%0d want 0/%0d/%0d",
                     i, a, l, to, ar_addr_log.size(), s_data_log.size(), exp_ar_addr.size(), exp_data.size());
         end else begin
            for (int j = 0; j < exp_ar_addr.size(); j++) begin
               total++;
               if ({ar_addr_log[j], ar_len_log[j]} !== {exp_ar_addr[j], exp_ar_len[j]}) begin
                  bad++;
                  $display("[TB] FAIL b2b%0d_ar%0d got addr=%h len=%0d want addr=%h len=%0d",
                           i, j, ar_addr_log[j], ar_len_log[j], exp_ar_addr[j], exp_ar_len[j]);
               end
            end
            for (int j = 0; j < exp_data.size(); j++) begin
               total++;
               if ({s_data_log[j], s_keep_log[j], s_last_log[j]} !== {exp_data[j], exp_keep[j], exp_last[j]}) begin
                  bad++;
                  $display("[TB] FAIL b2b%0d_beat%0d got data=%h keep=%h last=%b want data=%h keep=%h last=%b",
                           i, j, s_data_log[j][63:0], s_keep_log[j], s_last_log[j], exp_data[j][63:0], exp_keep[j], exp_last[j]);
               end
            end
         end
      end
      rnd_tready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int n;
      bit to;
      clear_logs();
      @(posedge clk); #1;
      s_cmd_addr = 34'h8000; s_cmd_len = 20'd1024; s_cmd_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      s_cmd_valid = 1'b0;
      n = 0;
      while (s_data_log.size() < 3 && n < 2000) begin @(negedge clk); n++; end
      total++;
      if (n >= 2000) begin bad++; $display("[TB] FAIL reset_mid_start got beats=%0d want>=3", s_data_log.size()); end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({arvalid, rready, tvalid, busy, s_cmd_ready} !== 5'b00001) begin
         bad++;
         $display("[TB] FAIL reset_mid_outputs got=%b want=00001", {arvalid, rready, tvalid, busy, s_cmd_ready});
      end
      clear_logs();
      repeat (100) @(negedge clk);
      total++;
      if (ar_addr_log.size() != 0 || s_data_log.size() != 0) begin
         bad++;
         $display("[TB] FAIL reset_mid_quiet got ars=%0d beats=%0d want 0/0", ar_addr_log.size(), s_data_log.size());
      end
      clear_logs();
      build_expected(34'h9000, 192);
      do_cmd(34'h9000, 20'd192, to);
      total++;
      if (to || s_data_log.size() != 3 || s_data_log[0] !== exp_data[0] || s_last_log[2] !== 1'b1) begin
         bad++;
         $display("[TB] FAIL reset_mid_recover got to=%0d beats=%0d want 0/3 with matching data", to, s_data_log.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      s_cmd_valid = 1'b0;
      s_cmd_addr = '0;
      s_cmd_len = '0;
      test_reset();
      test_directed();
      test_zero_len();
      test_error();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
